// File: rtl/sdfm_result_arbiter.sv
// SDFM result arbiter: captures per-channel filter results into holding
// registers, round-robins them into a shared tagged FIFO, flags overruns
// and raises a level interrupt on FIFO fill or overrun.
module sdfm_result_arbiter #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic            SYSCLK,
    input  logic            SYSRST,
    input  logic [2*DW-1:0] filt_data_outx,
    input  logic [1:0]      filt_data_updatex,
    input  logic [1:0]      reg_chen,
    input  logic [CW-1:0]   reg_irqthr,
    input  logic            pop,
    input  logic [1:0]      ovf_clr,
    output logic [DW-1:0]   fifo_data,
    output logic            fifo_chan,
    output logic            fifo_valid,
    output logic [CW-1:0]   fifo_count,
    output logic [1:0]      ovf_flag,
    output logic            irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [DW-1:0] hold_q [2];
    logic [DW-1:0] hold_d [2];
    logic [1:0]    pend_q, pend_d;
    logic          last_q, last_d;
    logic [DW:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    ovf_q, ovf_d;
    logic          irq_q, irq_d;

    logic [1:0] cap;
    logic [1:0] elig;
    logic       can_push;
    logic       push;
    logic       grant_ch;
    logic       pop_eff;

    // Arbitration, capture, overrun and interrupt next-state
    always_comb begin
        cap      = filt_data_updatex & reg_chen;
        // A disabled channel's held result is dropped, so it is never eligible
        elig     = pend_q & reg_chen;
        pop_eff  = pop && (count_q != '0);
        can_push = (count_q < FullCnt) || pop_eff;
        push     = can_push && (elig != 2'b00);
        grant_ch = (elig == 2'b11) ? ~last_q : elig[1];
        last_d   = push ? grant_ch : last_q;
        count_d  = count_q + CW'(push) - CW'(pop_eff);

        for (int i = 0; i < 2; i++) begin
            hold_d[i] = cap[i] ? filt_data_outx[DW*i +: DW] : hold_q[i];
            if (!reg_chen[i]) begin
                pend_d[i] = 1'b0;
            end else if (cap[i]) begin
                pend_d[i] = 1'b1;
            end else if (push && (grant_ch == 1'(i))) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
            // Set beats clear
            if (cap[i] && pend_q[i] && !(push && (grant_ch == 1'(i)))) begin
                ovf_d[i] = 1'b1;
            end else if (ovf_clr[i]) begin
                ovf_d[i] = 1'b0;
            end else begin
                ovf_d[i] = ovf_q[i];
            end
        end

        // Built from current registered state, so irq trails count/flags by a cycle
        irq_d = ((reg_irqthr != '0) && (count_q >= reg_irqthr)) || (ovf_q != 2'b00);
    end

    // State registers with synchronous reset
    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            hold_q[0] <= '0;
            hold_q[1] <= '0;
            pend_q    <= '0;
            last_q    <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= '0;
            irq_q     <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            hold_q[0] <= hold_d[0];
            hold_q[1] <= hold_d[1];
            pend_q    <= pend_d;
            last_q    <= last_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {grant_ch, hold_q[grant_ch]};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Show-ahead head, forced to zero while empty
    always_comb begin
        fifo_valid = (count_q != '0);
        fifo_data  = fifo_valid ? mem_q[rd_ptr_q][DW-1:0] : '0;
        fifo_chan  = fifo_valid ? mem_q[rd_ptr_q][DW] : 1'b0;
        fifo_count = count_q;
        ovf_flag   = ovf_q;
        irq        = irq_q;
    end

endmodule
